circuito_jogo_param: RTL and testbench
======================================

# circuito_jogo_param

Parametrised memory-game controller (Genius-style): the player replays a growing sequence of button presses stored in on-chip memory, with a per-press timeout. Generalises the fixed 4-button/16-entry game to N buttons and configurable depth. Adds two sequence-growth modes: player-appended or internally generated with LED display. Top of the game datapath; the board wrapper feeds buttons and drives hex displays from the db_* outputs.

## Interface
- N_BOTOES, 4: number of buttons/LEDs, 2..8
- PROFUNDIDADE, 16: max sequence length (rounds), power of 2, 2..256
- TIMEOUT, 5000: cycles allowed per press (5 s at 1 kHz)
- T_MOSTRA, 500: cycles a generated jogada is shown on leds (modo=0)
- LFSR_SEED, 16'hACE1: LFSR reset value, nonzero
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; forces state inicial
- jogar  in  1  start/restart request, level-sampled
- modo  in  1  sampled in preparacao: 1 = player appends new jogada, 0 = generated by LFSR
- botoes  in  N_BOTOES  raw button levels (already debounced)
- leds  out  N_BOTOES  button echo / generated jogada display
- ganhou, perdeu, pronto  out  1  game result flags
- db_estado  out  4  FSM state code
- db_rodada  out  clog2(PROFUNDIDADE)  current round r
- db_contagem  out  clog2(PROFUNDIDADE)  index of jogada being compared
- db_memoria  out  N_BOTOES  memory word at db_contagem
- db_jogada  out  N_BOTOES  last registered press
- db_timeout, db_igual  out  1  timeout tick; registered press equals memory word

## Operation
- States (code): inicial 0, preparacao 1, espera_jogada 2, registra 3, compara 4, proxima_jogada 5, espera_nova 6, grava_nova 7, mostra_nova 8, proxima_rodada 9, final_acertou A, final_errou B, final_timeout C.
- Press event: botoes registered each cycle; event = previous sample all-zero and current nonzero. Held buttons produce one event.
- inicial: all outputs 0; jogar=1 -> preparacao.
- preparacao (1 cycle): latch modo; r=0, contagem=0; mem[0] = 1 (bit 0) if modo=1, else one-hot of LFSR; -> espera_jogada.
- espera_jogada: event -> registra; timeout -> final_timeout.
- registra: store press in db_jogada; -> compara.
- compara: press not one-hot or != mem[contagem] -> final_errou. Equal and contagem<r -> proxima_jogada (contagem+1, -> espera_jogada). Equal and contagem==r: r==PROFUNDIDADE-1 -> final_acertou; else modo=1 -> espera_nova, modo=0 -> grava_nova.
- espera_nova: event -> grava_nova with press; timeout -> final_timeout. A non-one-hot press -> final_errou.
- grava_nova: write mem[r+1] (press, or one-hot of LFSR mod N_BOTOES); modo=0 -> mostra_nova, else -> proxima_rodada.
- mostra_nova: leds = new word for T_MOSTRA cycles -> proxima_rodada.
- proxima_rodada: r+1, contagem=0 -> espera_jogada.
- Final states: pronto=1; ganhou=1 in final_acertou; perdeu=1 in final_errou/final_timeout. Held until jogar=1 -> preparacao (memory not cleared; overwritten as game proceeds).
- leds = registered botoes in espera_jogada/espera_nova, new word in mostra_nova, 0 elsewhere.
- LFSR 16-bit, taps 16,14,13,11, free-running every non-reset cycle.

## Timing
- Reset: state inicial, all outputs 0, r=contagem=0, LFSR=LFSR_SEED; memory contents undefined.
- Timeout counter clears on entry to espera_jogada/espera_nova; db_timeout pulses 1 cycle at count TIMEOUT-1; exit on that cycle.
- Press edge at cycle t (botoes nonzero) -> event t+1 -> registra t+1 -> compara t+2 -> perdeu/next state visible t+3.
- Event and timeout in same cycle: event wins.
- jogar ignored outside inicial and final states; reset wins over everything, mid-game included.

## Structure
- Package jogo_pkg: state codes, LFSR taps, function is_onehot, function onehot_of(index).
- Sub-module gerador_jogada: LFSR plus mod-N one-hot mapping; FSM, counters, and memory (inferred RAM, sync write) in top.

## Test plan
- Reset, jogar 10 cycles, modo=1; round 0 press 0001, append 0010; round 1 press 0001, 0010 -> db_rodada=1, then wait -> final_timeout, perdeu=1, pronto=1, ganhou=0.
- modo=1, round 0 press 0100 -> final_errou 3 cycles after press edge, db_igual=0.
- Press 0011 during espera_jogada -> final_errou (non-one-hot).
- PROFUNDIDADE=4, modo=1: complete 4 rounds correctly -> ganhou=1 after last compara; jogar -> preparacao.
- modo=0, N_BOTOES=6: leds show generated word for T_MOSTRA cycles; replaying it advances r; word always one-hot within 6 bits.
- Reset asserted in espera_nova -> inicial next cycle, all outputs 0.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game controller.
// State codes, LFSR tap mask and one-hot helper functions.
package jogo_pkg;

    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        espera_jogada  = 4'h2,
        registra       = 4'h3,
        compara        = 4'h4,
        proxima_jogada = 4'h5,
        espera_nova    = 4'h6,
        grava_nova     = 4'h7,
        mostra_nova    = 4'h8,
        proxima_rodada = 4'h9,
        final_acertou  = 4'hA,
        final_errou    = 4'hB,
        final_timeout  = 4'hC
    } estado_t;

    // Taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [7:0] onehot_of(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/gerador_jogada.sv
// Free-running 16-bit LFSR mapped to a one-hot jogada of N_BOTOES bits.
// Ports: clock, reset (sync, high), jogada (one-hot of lfsr mod N_BOTOES).
module gerador_jogada
    import jogo_pkg::*;
#(
    parameter int          N_BOTOES  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    output logic [N_BOTOES-1:0] jogada
);

    logic [15:0] lfsr;
    logic [2:0]  idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_comb begin
        idx    = 3'(lfsr % 16'(N_BOTOES));
        jogada = N_BOTOES'(onehot_of(idx));
    end

endmodule

// File: rtl/circuito_jogo_param.sv
// Genius-style memory game: FSM, round/index counters, timer and sequence RAM.
// Ports: clock, reset, jogar, modo, botoes in; leds, ganhou/perdeu/pronto, db_* debug out.
module circuito_jogo_param
    import jogo_pkg::*;
#(
    parameter int          N_BOTOES     = 4,
    parameter int          PROFUNDIDADE = 16,
    parameter int          TIMEOUT      = 5000,
    parameter int          T_MOSTRA     = 500,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            jogar,
    input  logic                            modo,
    input  logic [N_BOTOES-1:0]             botoes,
    output logic [N_BOTOES-1:0]             leds,
    output logic                            ganhou,
    output logic                            perdeu,
    output logic                            pronto,
    output logic [3:0]                      db_estado,
    output logic [$clog2(PROFUNDIDADE)-1:0] db_rodada,
    output logic [$clog2(PROFUNDIDADE)-1:0] db_contagem,
    output logic [N_BOTOES-1:0]             db_memoria,
    output logic [N_BOTOES-1:0]             db_jogada,
    output logic                            db_timeout,
    output logic                            db_igual
);

    localparam int AW   = $clog2(PROFUNDIDADE);
    localparam int TMAX = (TIMEOUT > T_MOSTRA) ? TIMEOUT : T_MOSTRA;
    localparam int TW   = $clog2(TMAX + 1);

    estado_t             estado, prox;
    logic [N_BOTOES-1:0] botoes_reg, botoes_ant, nova, gerada;
    logic [N_BOTOES-1:0] mem [PROFUNDIDADE];
    logic [N_BOTOES-1:0] mem_dado, palavra;
    logic [AW-1:0]       rodada, contagem, mem_addr;
    logic [TW-1:0]       tmr;
    logic                modo_lat, mem_we;
    logic                evento, esperando, fim_timeout, fim_mostra, jogada_ok;

    gerador_jogada #(
        .N_BOTOES (N_BOTOES),
        .LFSR_SEED(LFSR_SEED)
    ) u_gerador (
        .clock (clock),
        .reset (reset),
        .jogada(gerada)
    );

    assign palavra     = mem[contagem];
    assign evento      = (botoes_ant == '0) && (botoes_reg != '0);
    assign esperando   = (estado == espera_jogada) || (estado == espera_nova);
    assign fim_timeout = esperando && (tmr == TW'(TIMEOUT - 1));
    assign fim_mostra  = (estado == mostra_nova) && (tmr == TW'(T_MOSTRA - 1));
    assign jogada_ok   = is_onehot(8'(db_jogada)) && (db_jogada == palavra);

    always_comb begin
        prox = estado;
        unique case (estado)
            inicial:        if (jogar) prox = preparacao;
            preparacao:     prox = espera_jogada;
            espera_jogada: begin
                if (evento)           prox = registra;
                else if (fim_timeout) prox = final_timeout;
            end
            registra:       prox = compara;
            compara: begin
                if (!jogada_ok)
                    prox = final_errou;
                else if (contagem != rodada)
                    prox = proxima_jogada;
                else if (rodada == AW'(PROFUNDIDADE - 1))
                    prox = final_acertou;
                else if (modo_lat)
                    prox = espera_nova;
                else
                    prox = grava_nova;
            end
            proxima_jogada: prox = espera_jogada;
            espera_nova: begin
                if (evento)
                    prox = is_onehot(8'(botoes_reg)) ? grava_nova : final_errou;
                else if (fim_timeout)
                    prox = final_timeout;
            end
            grava_nova:     prox = modo_lat ? proxima_rodada : mostra_nova;
            mostra_nova:    if (fim_mostra) prox = proxima_rodada;
            proxima_rodada: prox = espera_jogada;
            final_acertou,
            final_errou,
            final_timeout:  if (jogar) prox = preparacao;
            default:        prox = inicial;
        endcase
    end

    // Word 0 uses the live modo input: modo_lat is only valid afterwards.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_dado = gerada;
        if (estado == preparacao) begin
            mem_we   = 1'b1;
            mem_dado = modo ? N_BOTOES'(1) : gerada;
        end else if (estado == grava_nova) begin
            mem_we   = 1'b1;
            mem_addr = rodada + 1'b1;
            mem_dado = modo_lat ? nova : gerada;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_dado;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= inicial;
            botoes_reg <= '0;
            botoes_ant <= '0;
            modo_lat   <= 1'b0;
            rodada     <= '0;
            contagem   <= '0;
            tmr        <= '0;
            db_jogada  <= '0;
            nova       <= '0;
        end else begin
            estado     <= prox;
            botoes_reg <= botoes;
            botoes_ant <= botoes_reg;
            // Timer runs only while staying in a timed state; any entry restarts it.
            if ((esperando || estado == mostra_nova) && prox == estado)
                tmr <= tmr + 1'b1;
            else
                tmr <= '0;
            case (estado)
                preparacao: begin
                    modo_lat <= modo;
                    rodada   <= '0;
                    contagem <= '0;
                end
                espera_jogada:  if (evento) db_jogada <= botoes_reg;
                espera_nova:    if (evento) nova <= botoes_reg;
                grava_nova:     if (!modo_lat) nova <= gerada;
                proxima_jogada: contagem <= contagem + 1'b1;
                proxima_rodada: begin
                    rodada   <= rodada + 1'b1;
                    contagem <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        leds = '0;
        if (esperando)                 leds = botoes_reg;
        else if (estado == mostra_nova) leds = nova;
    end

    assign ganhou      = (estado == final_acertou);
    assign perdeu      = (estado == final_errou) || (estado == final_timeout);
    assign pronto      = ganhou || perdeu;
    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_contagem = contagem;
    assign db_memoria  = (estado == inicial) ? '0 : palavra;
    assign db_timeout  = fim_timeout;
    assign db_igual    = (estado != inicial) && (db_jogada == palavra);

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Randomized game-playing bench for circuito_jogo_param.
// A scripted player replays a modelled sequence and checks flags, states and leds.
module tb_circuito_jogo_param;

    localparam int N  = 6;
    localparam int P  = 4;
    localparam int TO = 20;
    localparam int TM = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         jogar = 1'b0;
    logic         modo = 1'b0;
    logic [N-1:0] botoes = '0;
    logic [N-1:0] leds, db_memoria, db_jogada;
    logic         ganhou, perdeu, pronto, db_timeout, db_igual;
    logic [3:0]   db_estado;
    logic [1:0]   db_rodada, db_contagem;
    logic [15:0]  m;
    logic [N-1:0] seq [$];
    int           total = 0;
    int           bad = 0;

    circuito_jogo_param #(
        .N_BOTOES    (N),
        .PROFUNDIDADE(P),
        .TIMEOUT     (TO),
        .T_MOSTRA    (TM),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .jogar      (jogar),
        .modo       (modo),
        .botoes     (botoes),
        .leds       (leds),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .pronto     (pronto),
        .db_estado  (db_estado),
        .db_rodada  (db_rodada),
        .db_contagem(db_contagem),
        .db_memoria (db_memoria),
        .db_jogada  (db_jogada),
        .db_timeout (db_timeout),
        .db_igual   (db_igual)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, stepped every non-reset cycle
    always @(posedge clk) begin
        if (reset) m <= 16'hACE1;
        else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [N-1:0] gen(input logic [15:0] v);
        logic [N-1:0] w;
        w = '0;
        w[v % 16'd6] = 1'b1;
        return w;
    endfunction

    function automatic logic [N-1:0] rand_oh();
        logic [N-1:0] w;
        w = '0;
        w[$urandom_range(0, N - 1)] = 1'b1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_est"}, 32'(db_estado), 0);
        chk({tag, "_leds"}, 32'(leds), 0);
        chk({tag, "_flags"}, 32'({ganhou, perdeu, pronto}), 0);
        chk({tag, "_rod"}, 32'({db_rodada, db_contagem}), 0);
        chk({tag, "_mem"}, 32'(db_memoria), 0);
        chk({tag, "_jog"}, 32'(db_jogada), 0);
        chk({tag, "_dbg"}, 32'({db_timeout, db_igual}), 0);
    endtask

    // Leaves the bench at the negedge three edges after the press was sampled.
    task automatic press(input logic [N-1:0] w);
        @(negedge clk);
        botoes = w;
        @(negedge clk);
        botoes = '0;
        chk("echo", 32'(leds), 32'(w));
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_game(input logic md);
        @(negedge clk);
        modo  = md;
        jogar = 1'b1;
        @(negedge clk);
        jogar = 1'b0;
        chk("prep", 32'(db_estado), 1);
        seq.delete();
        seq.push_back(md ? N'(1) : gen(m));
        @(negedge clk);
        chk("start", 32'(db_estado), 2);
    endtask

    task automatic lost(input string tag, input int est);
        chk({tag, "_est"}, 32'(db_estado), 32'(est));
        chk({tag, "_flags"}, 32'({ganhou, perdeu, pronto}), 32'(3'b011));
    endtask

    // err_rd: round where the last replay press goes wrong (-1 = none)
    // kind: 0 wrong one-hot, 1 non-one-hot, 2 timeout
    task automatic play(input logic md, input int err_rd, input int kind);
        logic [N-1:0] w;
        int k;
        start_game(md);
        for (int rd = 0; rd < P; rd++) begin
            chk("rodada", 32'(db_rodada), 32'(rd));
            for (int i = 0; i <= rd; i++) begin
                chk("contagem", 32'(db_contagem), 32'(i));
                chk("memoria", 32'(db_memoria), 32'(seq[i]));
                if (rd == err_rd && i == rd && kind == 2) begin
                    repeat (TO - 1) @(negedge clk);
                    chk("tick", 32'({db_timeout, db_estado}), 32'h12);
                    @(negedge clk);
                    lost("tmo", 4'hC);
                    return;
                end
                w = seq[i];
                if (rd == err_rd && i == rd) begin
                    k = $urandom_range(1, N - 1);
                    if (kind == 0) w = (w << k) | (w >> (N - k));
                    else w = w | ((w == N'(1)) ? N'(2) : N'(1));
                end
                press(w);
                if (w != seq[i]) begin
                    lost("errou", 4'hB);
                    chk("igual", 32'(db_igual), 0);
                    return;
                end
                if (i < rd) begin
                    chk("prox", 32'(db_estado), 5);
                    @(negedge clk);
                end else if (rd == P - 1) begin
                    chk("win_est", 32'(db_estado), 32'hA);
                    chk("win_flags", 32'({ganhou, perdeu, pronto}), 32'(3'b101));
                    return;
                end else if (md) begin
                    chk("nova", 32'(db_estado), 6);
                    w = rand_oh();
                    press(w);
                    chk("apendou", 32'(db_estado), 2);
                    seq.push_back(w);
                end else begin
                    chk("grava", 32'(db_estado), 7);
                    w = gen(m);
                    seq.push_back(w);
                    for (int c = 0; c < TM; c++) begin
                        @(negedge clk);
                        chk("mostra", 32'({db_estado, leds}), 32'({4'h8, w}));
                    end
                    @(negedge clk);
                    chk("prox_rod", 32'({db_estado, leds}), 32'({4'h9, 6'd0}));
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        int e;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle", 32'(db_estado), 0);

        play(1'b1, -1, 0);
        play(1'b1, 0, 0);
        play(1'b1, 1, 2);
        play(1'b1, 0, 1);
        play(1'b0, -1, 0);
        play(1'b0, 2, 0);
        play(1'b0, 1, 2);
        for (int g = 0; g < 8; g++) begin
            e = $urandom_range(0, P);
            if (e == P) e = -1;
            play(1'($urandom_range(0, 1)), e, $urandom_range(0, 2));
        end

        start_game(1'b1);
        press(N'(1));
        chk("nova_rst", 32'(db_estado), 6);
        @(negedge clk);
        jogar = 1'b1;
        @(negedge clk);
        jogar = 1'b0;
        chk("jogar_ign", 32'(db_estado), 6);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midreset");
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
